alu_arbiter: RTL
================

Name: alu_arbiter

Overview:
- Shares one combinational ArithmeticLogicUnit between two requesters, e.g. the integer pipeline (port 0) and the branch/address unit (port 1).
- Each requester issues operations over a valid/ready handshake.
- Arbitration is round-robin; at most one operation is granted per cycle.
- Each requester receives its result in a private one-entry response register with its own valid/ready handshake.

Parameters:
XLEN, 32, operand/result width (must match ALU)
TAG_W, 4, width of requester-supplied tag echoed with the result
CNT_W, 16, width of per-requester saturating stall counters

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
req_valid  input  2  per-requester request valid
req_ready  output  2  per-requester accept (combinational grant)
req_op  input  2 x InstructionSetALU  operation select per requester
req_in1  input  2 x XLEN  main operand 1
req_in2  input  2 x XLEN  main operand 2
req_in1_b  input  2 x XLEN  secondary-compare operand 1
req_in2_b  input  2 x XLEN  secondary-compare operand 2
req_tag  input  2 x TAG_W  tag returned with result
rsp_valid  output  2  result held for requester
rsp_ready  input  2  requester consumes result
rsp_out  output  2 x XLEN  registered ALU out
rsp_out_b  output  2  registered ALU out_b
rsp_tag  output  2 x TAG_W  registered tag
stall_cnt  output  2 x CNT_W  cycles with req_valid high and req_ready low, saturating

Behaviour:
- Clock and reset:
  - One clock domain; reset is synchronous, active-high.
  - Reset values: rsp_valid=0, rsp_out=0, rsp_out_b=0, rsp_tag=0, stall_cnt=0, rr_ptr=0 (requester 0 has priority first).
  - Reset asserted mid-operation discards held responses and in-flight grants. req_ready is 0 while reset is high.
- Eligibility: elig[i] = req_valid[i] && (!rsp_valid[i] || rsp_ready[i]). A full response slot may accept only when it drains in the same cycle.
- Grant:
  - Exactly one eligible requester: it wins.
  - Both eligible: requester rr_ptr wins.
  - None eligible: no grant.
  - req_ready[i] = grant[i]. It is combinational from req_valid, rsp_valid, rsp_ready and rr_ptr, and does not depend on req_op or data.
- Round-robin pointer: on a grant to i, rr_ptr <= ~i; without a grant, rr_ptr holds. Under continuous dual requests, grants alternate 0,1,0,1…
- ALU mux:
  - The granted requester's op/in1/in2/in1_b/in2_b drive the ALU instance.
  - With no grant, op=all-zero (NOP) and operands=0.
- Response register, per i:
  - Grant to i: rsp_valid[i]<=1; rsp_out/out_b/tag <= ALU out/out_b/req_tag[i].
  - Else if rsp_ready[i]: rsp_valid[i]<=0, data held.
  - Else: hold.
- Latency and throughput:
  - Latency is 1 cycle from handshake to rsp_valid.
  - Throughput is 1 operation/cycle aggregate, and 1/cycle per requester when that requester holds rsp_ready high and has no competition.
- Results are bit-exact with the ALU: XLEN-wide wrap-around add/sub, shift amount = in2[4:0], out_b as produced by the SLT_B/SLTU_B/SEQ_B flags.
- stall_cnt[i] increments when req_valid[i] && !req_ready[i] and saturates at all-ones (no wrap). It is cleared only by reset.
- Requesters may change or drop request fields while not granted; no stability rule is imposed.

Decomposition:
- Shared package (existing ALU package):
  - InstructionSetALU typedef, already present.
  - Add localparam ALU_NUM_REQ=2.
  - Add typedef alu_req_t bundling op, in1, in2, in1_b, in2_b, tag.
- Sub-modules:
  - One instance of the existing ArithmeticLogicUnit.
  - Grant logic plus rr_ptr in one small sub-module, rr_arbiter2 (inputs elig[1:0]; outputs grant[1:0]; holds rr_ptr).

Test Plan:
- Single request: req0 ADD in1=5 in2=7, tag=3, rsp_ready0=1 → req_ready0=1 same cycle; next cycle rsp_valid0=1, rsp_out0=12, rsp_tag0=3; rsp_valid1 stays 0.
- Contention: both valid every cycle, rsp_ready=2'b11, req0 SUB 10-3, req1 XOR 6^3 → grants alternate 0,1,0,1 starting at 0; results 7 and 5 on the correct ports; each stall_cnt increments once per lost cycle.
- Backpressure: req0 SLT_B (op ADD|SLT_B) in1=-2 in2=1, rsp_ready0=0 → rsp_out0=-1, rsp_out_b0=1 held. A second req0 sees req_ready0=0 until rsp_ready0=1, then is accepted in that same cycle. Meanwhile req1 is granted every cycle.
- Saturation: CNT_W=4, hold req0 blocked for 20 cycles → stall_cnt0 stops at 15.
- Reset mid-operation: response held and both requests pending, assert reset 1 cycle → rsp_valid=00, stall_cnt=0, and the first grant after reset goes to requester 0.
- Sweep: random ops/operands for 1000 transactions through both ports with random rsp_ready → every result matches a reference ALU model, in per-port issue order, with no lost or duplicated tags.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// Shared ALU package: opcode encoding, requester count and request payload.
package alu_arbiter_pkg;

  localparam int unsigned ALU_XLEN    = 32;
  localparam int unsigned ALU_TAG_W   = 4;
  localparam int unsigned ALU_OP_W    = 7;
  localparam int unsigned ALU_NUM_REQ = 2;

  // Bits [3:0] select the main result, bits [6:4] enable out_b compare flags.
  typedef logic [ALU_OP_W-1:0] InstructionSetALU;

  localparam InstructionSetALU ALU_MAIN_MASK = 7'h0F;
  localparam InstructionSetALU ALU_NOP       = 7'h00;
  localparam InstructionSetALU ALU_ADD       = 7'h01;
  localparam InstructionSetALU ALU_SUB       = 7'h02;
  localparam InstructionSetALU ALU_AND       = 7'h03;
  localparam InstructionSetALU ALU_OR        = 7'h04;
  localparam InstructionSetALU ALU_XOR       = 7'h05;
  localparam InstructionSetALU ALU_SLL       = 7'h06;
  localparam InstructionSetALU ALU_SRL       = 7'h07;
  localparam InstructionSetALU ALU_SRA       = 7'h08;
  localparam InstructionSetALU ALU_SLT       = 7'h09;
  localparam InstructionSetALU ALU_SLTU      = 7'h0A;
  localparam InstructionSetALU ALU_SLT_B     = 7'h10;
  localparam InstructionSetALU ALU_SLTU_B    = 7'h20;
  localparam InstructionSetALU ALU_SEQ_B     = 7'h40;

  typedef struct packed {
    InstructionSetALU       op;
    logic [ALU_XLEN-1:0]    in1;
    logic [ALU_XLEN-1:0]    in2;
    logic [ALU_XLEN-1:0]    in1_b;
    logic [ALU_XLEN-1:0]    in2_b;
    logic [ALU_TAG_W-1:0]   tag;
  } alu_req_t;

endpackage

// File: rtl/ArithmeticLogicUnit.sv
// Combinational ALU: main result plus an OR of the enabled secondary compares.
module ArithmeticLogicUnit
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned XLEN = ALU_XLEN
) (
  input  InstructionSetALU  i_op,
  input  logic [XLEN-1:0]   i_in1,
  input  logic [XLEN-1:0]   i_in2,
  input  logic [XLEN-1:0]   i_in1_b,
  input  logic [XLEN-1:0]   i_in2_b,
  output logic [XLEN-1:0]   o_out,
  output logic              o_out_b
);

  InstructionSetALU w_main;
  logic [4:0]       w_shamt;

  assign w_shamt = i_in2[4:0];

  // Main result select; undefined encodings produce zero.
  always_comb begin
    w_main = i_op & ALU_MAIN_MASK;
    o_out  = '0;
    case (w_main)
      ALU_ADD:  o_out = i_in1 + i_in2;
      ALU_SUB:  o_out = i_in1 - i_in2;
      ALU_AND:  o_out = i_in1 & i_in2;
      ALU_OR:   o_out = i_in1 | i_in2;
      ALU_XOR:  o_out = i_in1 ^ i_in2;
      ALU_SLL:  o_out = i_in1 << w_shamt;
      ALU_SRL:  o_out = i_in1 >> w_shamt;
      ALU_SRA:  o_out = XLEN'($signed(i_in1) >>> w_shamt);
      ALU_SLT:  o_out = XLEN'($signed(i_in1) < $signed(i_in2));
      ALU_SLTU: o_out = XLEN'(i_in1 < i_in2);
      default:  o_out = '0;
    endcase
  end

  assign o_out_b = ((|(i_op & ALU_SLT_B))  && ($signed(i_in1_b) < $signed(i_in2_b))) ||
                   ((|(i_op & ALU_SLTU_B)) && (i_in1_b < i_in2_b)) ||
                   ((|(i_op & ALU_SEQ_B))  && (i_in1_b == i_in2_b));

endmodule

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; the winner of a grant loses priority next time.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] i_elig,
  output logic [1:0] o_grant_c
);

  logic r_rr_ptr;

  // Grant the single eligible requester, or the pointed one on a tie.
  always_comb begin
    o_grant_c = 2'b00;
    case (i_elig)
      2'b01:   o_grant_c = 2'b01;
      2'b10:   o_grant_c = 2'b10;
      2'b11:   o_grant_c = r_rr_ptr ? 2'b10 : 2'b01;
      default: o_grant_c = 2'b00;
    endcase
  end

  // Priority moves to the requester that did not just win; idle cycles hold it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr_ptr <= 1'b0;
    end else if (o_grant_c[0]) begin
      r_rr_ptr <= 1'b1;
    end else if (o_grant_c[1]) begin
      r_rr_ptr <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two requesters with per-requester response slots.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned XLEN  = ALU_XLEN,
  parameter int unsigned TAG_W = ALU_TAG_W,
  parameter int unsigned CNT_W = 16
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [ALU_NUM_REQ-1:0]                req_valid,
  output logic [ALU_NUM_REQ-1:0]                req_ready,
  input  logic [ALU_NUM_REQ-1:0][ALU_OP_W-1:0]  req_op,
  input  logic [ALU_NUM_REQ-1:0][XLEN-1:0]      req_in1,
  input  logic [ALU_NUM_REQ-1:0][XLEN-1:0]      req_in2,
  input  logic [ALU_NUM_REQ-1:0][XLEN-1:0]      req_in1_b,
  input  logic [ALU_NUM_REQ-1:0][XLEN-1:0]      req_in2_b,
  input  logic [ALU_NUM_REQ-1:0][TAG_W-1:0]     req_tag,
  output logic [ALU_NUM_REQ-1:0]                rsp_valid,
  input  logic [ALU_NUM_REQ-1:0]                rsp_ready,
  output logic [ALU_NUM_REQ-1:0][XLEN-1:0]      rsp_out,
  output logic [ALU_NUM_REQ-1:0]                rsp_out_b,
  output logic [ALU_NUM_REQ-1:0][TAG_W-1:0]     rsp_tag,
  output logic [ALU_NUM_REQ-1:0][CNT_W-1:0]     stall_cnt
);

  logic [ALU_NUM_REQ-1:0]              w_elig;
  logic [ALU_NUM_REQ-1:0]              w_grant;
  alu_req_t                            w_alu_req;
  logic [XLEN-1:0]                     w_alu_out;
  logic                                w_alu_out_b;

  logic [ALU_NUM_REQ-1:0]              r_rsp_valid;
  logic [ALU_NUM_REQ-1:0][XLEN-1:0]    r_rsp_out;
  logic [ALU_NUM_REQ-1:0]              r_rsp_out_b;
  logic [ALU_NUM_REQ-1:0][TAG_W-1:0]   r_rsp_tag;
  logic [ALU_NUM_REQ-1:0][CNT_W-1:0]   r_stall_cnt;

  // A full slot can take a new result only if it drains this same cycle.
  assign w_elig    = {ALU_NUM_REQ{~reset}} & req_valid & (~r_rsp_valid | rsp_ready);
  assign req_ready = w_grant;

  rr_arbiter2 u_arb (
    .clk       (clk),
    .reset     (reset),
    .i_elig    (w_elig),
    .o_grant_c (w_grant)
  );

  // Steer the granted request into the ALU; idle cycles present a zero NOP.
  always_comb begin
    w_alu_req = '0;
    for (int i = 0; i < ALU_NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_alu_req.op    = req_op[i];
        w_alu_req.in1   = req_in1[i];
        w_alu_req.in2   = req_in2[i];
        w_alu_req.in1_b = req_in1_b[i];
        w_alu_req.in2_b = req_in2_b[i];
        w_alu_req.tag   = req_tag[i];
      end
    end
  end

  ArithmeticLogicUnit #(
    .XLEN (XLEN)
  ) u_alu (
    .i_op    (w_alu_req.op),
    .i_in1   (w_alu_req.in1),
    .i_in2   (w_alu_req.in2),
    .i_in1_b (w_alu_req.in1_b),
    .i_in2_b (w_alu_req.in2_b),
    .o_out   (w_alu_out),
    .o_out_b (w_alu_out_b)
  );

  // Response slots: load on grant, empty on consume, otherwise hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rsp_valid <= '0;
      r_rsp_out   <= '0;
      r_rsp_out_b <= '0;
      r_rsp_tag   <= '0;
    end else begin
      for (int i = 0; i < ALU_NUM_REQ; i++) begin
        if (w_grant[i]) begin
          r_rsp_valid[i] <= 1'b1;
          r_rsp_out[i]   <= w_alu_out;
          r_rsp_out_b[i] <= w_alu_out_b;
          r_rsp_tag[i]   <= w_alu_req.tag;
        end else if (rsp_ready[i]) begin
          r_rsp_valid[i] <= 1'b0;
        end
      end
    end
  end

  // Saturating count of cycles a requester waited without being granted.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else begin
      for (int i = 0; i < ALU_NUM_REQ; i++) begin
        if (req_valid[i] && !w_grant[i] && (r_stall_cnt[i] != {CNT_W{1'b1}})) begin
          r_stall_cnt[i] <= r_stall_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_out   = r_rsp_out;
  assign rsp_out_b = r_rsp_out_b;
  assign rsp_tag   = r_rsp_tag;
  assign stall_cnt = r_stall_cnt;

endmodule
